// File: rtl/cache_pkg.sv
// Shared definitions for the cache line mover: default geometry, FSM encoding
// and the line-to-RAM-base address helper.
package cache_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int LINE_WORDS = 8;
    localparam int LINE_BITS  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_FILL    = 3'd2,
        ST_FILL_WR = 3'd3,
        ST_WB_RD   = 3'd4,
        ST_WB_CAP  = 3'd5,
        ST_WB_SEND = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // First RAM word of a line; callers truncate to their address width.
    function automatic logic [31:0] line_base(input logic [31:0] idx, input int unsigned bits);
        return idx << bits;
    endfunction

endpackage

// File: rtl/cache_line_mover_if.sv
// Controller, memory-bus and quad-port RAM signals of the cache line mover.
// master = the mover, slave = the surrounding controller/bus/RAM.
interface cache_line_mover_if #(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int LINE_BITS  = cache_pkg::LINE_BITS
);
    logic                            fill_req;
    logic                            wb_req;
    logic [ADDR_WIDTH-LINE_BITS-1:0] line_idx;
    logic                            busy;
    logic                            done;
    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic                            mem_req_write;
    logic [ADDR_WIDTH-LINE_BITS-1:0] mem_req_line;
    logic [DATA_WIDTH-1:0]           mem_rdata;
    logic                            mem_rvalid;
    logic                            mem_rready;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic                            mem_wvalid;
    logic                            mem_wready;
    logic [ADDR_WIDTH-1:0]           ram_addr_a;
    logic [ADDR_WIDTH-1:0]           ram_addr_b;
    logic [ADDR_WIDTH-1:0]           ram_addr_c;
    logic [ADDR_WIDTH-1:0]           ram_addr_d;
    logic [DATA_WIDTH-1:0]           ram_data_a;
    logic [DATA_WIDTH-1:0]           ram_data_b;
    logic                            ram_we_a;
    logic                            ram_we_b;
    logic [DATA_WIDTH-1:0]           ram_q_c;
    logic [DATA_WIDTH-1:0]           ram_q_d;

    modport master (
        input  fill_req, wb_req, line_idx, mem_req_ready, mem_rdata, mem_rvalid,
               mem_wready, ram_q_c, ram_q_d,
        output busy, done, mem_req_valid, mem_req_write, mem_req_line, mem_rready,
               mem_wdata, mem_wvalid, ram_addr_a, ram_addr_b, ram_addr_c, ram_addr_d,
               ram_data_a, ram_data_b, ram_we_a, ram_we_b
    );

    modport slave (
        output fill_req, wb_req, line_idx, mem_req_ready, mem_rdata, mem_rvalid,
               mem_wready, ram_q_c, ram_q_d,
        input  busy, done, mem_req_valid, mem_req_write, mem_req_line, mem_rready,
               mem_wdata, mem_wvalid, ram_addr_a, ram_addr_b, ram_addr_c, ram_addr_d,
               ram_data_a, ram_data_b, ram_we_a, ram_we_b
    );
endinterface

// File: rtl/line_word_counter.sv
// Word-within-line counter shared by the fill and writeback paths.
module line_word_counter #(
    parameter int LINE_WORDS = 8,
    parameter int LINE_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [LINE_BITS-1:0] count,
    output logic                 last
);
    logic [LINE_BITS-1:0] count_r;

    // Clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {LINE_BITS{1'b0}};
        end else if (clr) begin
            count_r <= {LINE_BITS{1'b0}};
        end else if (inc) begin
            count_r <= count_r + LINE_BITS'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == LINE_BITS'(LINE_WORDS - 1));
endmodule

// File: rtl/cache_line_mover.sv
// Moves whole cache lines between the quad-port data RAM and backing memory.
// Every output is a register loaded from the next-state decode.
module cache_line_mover #(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int LINE_BITS  = cache_pkg::LINE_BITS
) (
    input logic                clk,
    input logic                rst_n,
    cache_line_mover_if.master bus
);
    import cache_pkg::*;

    localparam int IDX_W = ADDR_WIDTH - LINE_BITS;

    state_t                state_r, state_nxt_s;
    logic [LINE_BITS-1:0]  cnt_s, wb_next_off_s;
    logic                  cnt_last_s, cnt_clr_s, cnt_inc_s;
    logic [ADDR_WIDTH-1:0] base_s;
    logic [DATA_WIDTH-1:0] even_r, even_nxt_s, buf_d_r, buf_d_nxt_s, wdata_r, wdata_nxt_s;
    logic [DATA_WIDTH-1:0] data_a_r, data_a_nxt_s, data_b_r, data_b_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_a_r, addr_a_nxt_s, addr_b_r, addr_b_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_c_r, addr_c_nxt_s, addr_d_r, addr_d_nxt_s;
    logic [IDX_W-1:0]      req_line_r, req_line_nxt_s;
    logic                  req_write_r, req_write_nxt_s, fill_last_r, fill_last_nxt_s;
    logic                  we_r, we_nxt_s, busy_r, done_r, req_valid_r, rready_r, wvalid_r;

    line_word_counter #(.LINE_WORDS(LINE_WORDS), .LINE_BITS(LINE_BITS)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .count (cnt_s),
        .last  (cnt_last_s)
    );

    // Line base has zero low bits, so word offsets are OR-ed in without carry.
    assign base_s        = ADDR_WIDTH'(line_base(32'(req_line_r), LINE_BITS));
    assign wb_next_off_s = cnt_s + LINE_BITS'(1'b1);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_clr_s       = 1'b0;
        cnt_inc_s       = 1'b0;
        req_write_nxt_s = req_write_r;
        req_line_nxt_s  = req_line_r;
        even_nxt_s      = even_r;
        buf_d_nxt_s     = buf_d_r;
        fill_last_nxt_s = fill_last_r;
        wdata_nxt_s     = wdata_r;
        addr_a_nxt_s    = addr_a_r;
        addr_b_nxt_s    = addr_b_r;
        addr_c_nxt_s    = addr_c_r;
        addr_d_nxt_s    = addr_d_r;
        data_a_nxt_s    = data_a_r;
        data_b_nxt_s    = data_b_r;
        we_nxt_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.wb_req) begin
                    state_nxt_s     = ST_REQ;
                    req_write_nxt_s = 1'b1;
                    req_line_nxt_s  = bus.line_idx;
                end else if (bus.fill_req) begin
                    state_nxt_s     = ST_REQ;
                    req_write_nxt_s = 1'b0;
                    req_line_nxt_s  = bus.line_idx;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_clr_s = 1'b1;
                    if (req_write_r) begin
                        state_nxt_s  = ST_WB_RD;
                        addr_c_nxt_s = base_s;
                        addr_d_nxt_s = base_s | ADDR_WIDTH'(1'b1);
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_FILL: begin
                if (bus.mem_rvalid) begin
                    cnt_inc_s = 1'b1;
                    if (cnt_s[0]) begin
                        state_nxt_s     = ST_FILL_WR;
                        addr_a_nxt_s    = base_s | ADDR_WIDTH'(cnt_s - LINE_BITS'(1'b1));
                        addr_b_nxt_s    = base_s | ADDR_WIDTH'(cnt_s);
                        data_a_nxt_s    = even_r;
                        data_b_nxt_s    = bus.mem_rdata;
                        we_nxt_s        = 1'b1;
                        fill_last_nxt_s = cnt_last_s;
                    end else begin
                        even_nxt_s = bus.mem_rdata;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FILL_WR: begin
                if (fill_last_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_WB_RD: begin
                state_nxt_s = ST_WB_CAP;
            end
            ST_WB_CAP: begin
                state_nxt_s = ST_WB_SEND;
                wdata_nxt_s = bus.ram_q_c;
                buf_d_nxt_s = bus.ram_q_d;
            end
            ST_WB_SEND: begin
                if (bus.mem_wready) begin
                    cnt_inc_s = 1'b1;
                    if (!cnt_s[0]) begin
                        wdata_nxt_s = buf_d_r;
                    end else if (cnt_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s  = ST_WB_RD;
                        addr_c_nxt_s = base_s | ADDR_WIDTH'(wb_next_off_s);
                        addr_d_nxt_s = base_s | ADDR_WIDTH'(wb_next_off_s) | ADDR_WIDTH'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_WB_SEND;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_write_r <= 1'b0;
            req_line_r  <= {IDX_W{1'b0}};
            even_r      <= {DATA_WIDTH{1'b0}};
            buf_d_r     <= {DATA_WIDTH{1'b0}};
            fill_last_r <= 1'b0;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            addr_a_r    <= {ADDR_WIDTH{1'b0}};
            addr_b_r    <= {ADDR_WIDTH{1'b0}};
            addr_c_r    <= {ADDR_WIDTH{1'b0}};
            addr_d_r    <= {ADDR_WIDTH{1'b0}};
            data_a_r    <= {DATA_WIDTH{1'b0}};
            data_b_r    <= {DATA_WIDTH{1'b0}};
            we_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            req_valid_r <= 1'b0;
            rready_r    <= 1'b0;
            wvalid_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_write_r <= req_write_nxt_s;
            req_line_r  <= req_line_nxt_s;
            even_r      <= even_nxt_s;
            buf_d_r     <= buf_d_nxt_s;
            fill_last_r <= fill_last_nxt_s;
            wdata_r     <= wdata_nxt_s;
            addr_a_r    <= addr_a_nxt_s;
            addr_b_r    <= addr_b_nxt_s;
            addr_c_r    <= addr_c_nxt_s;
            addr_d_r    <= addr_d_nxt_s;
            data_a_r    <= data_a_nxt_s;
            data_b_r    <= data_b_nxt_s;
            we_r        <= we_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
            req_valid_r <= (state_nxt_s == ST_REQ);
            rready_r    <= (state_nxt_s == ST_FILL);
            wvalid_r    <= (state_nxt_s == ST_WB_SEND);
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.mem_req_valid = req_valid_r;
    assign bus.mem_req_write = req_write_r;
    assign bus.mem_req_line  = req_line_r;
    assign bus.mem_rready    = rready_r;
    assign bus.mem_wdata     = wdata_r;
    assign bus.mem_wvalid    = wvalid_r;
    assign bus.ram_addr_a    = addr_a_r;
    assign bus.ram_addr_b    = addr_b_r;
    assign bus.ram_addr_c    = addr_c_r;
    assign bus.ram_addr_d    = addr_d_r;
    assign bus.ram_data_a    = data_a_r;
    assign bus.ram_data_b    = data_b_r;
    assign bus.ram_we_a      = we_r;
    assign bus.ram_we_b      = we_r;
endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: table of fill/writeback operations
// plus hand-written reset-abort sequence, against a quad-port RAM model.
module tb_cache_line_mover;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LB = 3;
    localparam int LW = 8;

    typedef struct {
        bit          is_wb;
        bit          both;
        bit [8:0]    line;
        bit          gap;
        int          req_delay;
        logic [31:0] first;
        int          exp_base;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_line_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BITS(LB)) bus ();

    cache_line_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .LINE_BITS(LB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] ram [0:4095];
    int   wr_count = 0;
    int   zero_wr  = 0;
    int   same_ab  = 0;
    logic clr_req  = 1'b0;
    int   clr_base = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl [7];

    // Quad-port RAM model with synchronous reads and write bookkeeping.
    always @(posedge clk) begin
        if (clr_req) begin
            for (int k = 0; k < LW; k++) ram[clr_base + k] <= 32'd0;
        end
        if (bus.ram_we_a) ram[bus.ram_addr_a] <= bus.ram_data_a;
        if (bus.ram_we_b) ram[bus.ram_addr_b] <= bus.ram_data_b;
        wr_count <= wr_count + (bus.ram_we_a ? 1 : 0) + (bus.ram_we_b ? 1 : 0);
        if ((bus.ram_we_a && bus.ram_addr_a == 12'd0) || (bus.ram_we_b && bus.ram_addr_b == 12'd0))
            zero_wr <= zero_wr + 1;
        if (bus.ram_we_a && bus.ram_we_b && bus.ram_addr_a == bus.ram_addr_b)
            same_ab <= same_ab + 1;
        bus.ram_q_c <= ram[bus.ram_addr_c];
        bus.ram_q_d <= ram[bus.ram_addr_d];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic any;
        any = bus.busy | bus.done | bus.mem_req_valid | bus.mem_req_write | (|bus.mem_req_line)
            | bus.mem_rready | (|bus.mem_wdata) | bus.mem_wvalid
            | (|bus.ram_addr_a) | (|bus.ram_addr_b) | (|bus.ram_addr_c) | (|bus.ram_addr_d)
            | (|bus.ram_data_a) | (|bus.ram_data_b) | bus.ram_we_a | bus.ram_we_b;
        check(name, 64'(any), 64'd0);
    endtask

    task automatic clear_line(input int base);
        clr_base = base;
        clr_req  = 1'b1;
        step();
        clr_req  = 1'b0;
    endtask

    task automatic run_fill(input bit [8:0] line, input logic [31:0] first, input bit gap,
                            input int delay, input int base);
        int i;
        int pairs;
        int dones;
        bit take;
        bus.line_idx = line;
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        check("fill_accept", {bus.busy, bus.mem_req_valid, bus.mem_req_write}, 3'b110);
        repeat (delay) step();
        check("fill_req_hold", {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_line}, {2'b10, line});
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        i = 0;
        pairs = 0;
        dones = 0;
        for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
            bus.mem_rvalid = (i < LW) && (!gap || (cyc % 2 == 1));
            bus.mem_rdata  = first + 32'(i);
            take = bus.mem_rvalid && bus.mem_rready;
            step();
            if (take) i++;
            if (bus.ram_we_a || bus.ram_we_b) begin
                check("fill_pair_we", {bus.ram_we_a, bus.ram_we_b}, 2'b11);
                check("fill_pair_addr", {bus.ram_addr_a, bus.ram_addr_b},
                      {12'(base + 2 * pairs), 12'(base + 2 * pairs + 1)});
                check("fill_pair_data", {bus.ram_data_a, bus.ram_data_b},
                      {first + 32'(2 * pairs), first + 32'(2 * pairs + 1)});
                check("fill_pair_complete", 64'(i >= 2 * pairs + 2), 64'd1);
                pairs++;
            end
            if (bus.done) begin
                dones++;
                check("fill_done_busy", 64'(bus.busy), 64'd1);
            end
        end
        bus.mem_rvalid = 1'b0;
        check("fill_done_seen", 64'(dones), 64'd1);
        check("fill_pairs", 64'(pairs), 64'd4);
        step();
        check("fill_done_single", {bus.done, bus.busy}, 2'b00);
        for (int k = 0; k < LW; k++) check("fill_ram", ram[base + k], first + 32'(k));
    endtask

    task automatic run_wb(input bit [8:0] line, input logic [31:0] first, input bit both);
        int j;
        int dones;
        int w0;
        bit tog;
        bit take;
        bus.line_idx = line;
        bus.wb_req   = 1'b1;
        bus.fill_req = both;
        step();
        bus.wb_req   = 1'b0;
        bus.fill_req = 1'b0;
        w0 = wr_count;
        check("wb_accept", {bus.busy, bus.mem_req_valid, bus.mem_req_write}, 3'b111);
        check("wb_req_line", bus.mem_req_line, line);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        j = 0;
        dones = 0;
        tog = 1'b1;
        for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
            take = 1'b0;
            if (bus.mem_wvalid) begin
                check("wb_data", bus.mem_wdata, first + 32'(j));
                bus.mem_wready = tog;
                take = tog;
                tog = !tog;
            end else begin
                bus.mem_wready = 1'b0;
            end
            step();
            if (take) j++;
            if (bus.done) dones++;
        end
        bus.mem_wready = 1'b0;
        check("wb_words", 64'(j), 64'd8);
        check("wb_done_seen", 64'(dones), 64'd1);
        check("wb_no_ram_write", 64'(wr_count - w0), 64'd0);
        step();
        check("wb_idle", {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        int i;
        int w0;
        bit take;
        bus.fill_req      = 1'b0;
        bus.wb_req        = 1'b0;
        bus.line_idx      = 9'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rdata     = 32'd0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_wready    = 1'b0;

        tbl[0] = '{is_wb: 1'b0, both: 1'b0, line: 9'd3,   gap: 1'b0, req_delay: 0, first: 32'd100, exp_base: 24};
        tbl[1] = '{is_wb: 1'b0, both: 1'b0, line: 9'd3,   gap: 1'b1, req_delay: 3, first: 32'd100, exp_base: 24};
        tbl[2] = '{is_wb: 1'b1, both: 1'b0, line: 9'd3,   gap: 1'b0, req_delay: 0, first: 32'd100, exp_base: 24};
        tbl[3] = '{is_wb: 1'b0, both: 1'b0, line: 9'd5,   gap: 1'b0, req_delay: 0, first: 32'd500, exp_base: 40};
        tbl[4] = '{is_wb: 1'b1, both: 1'b1, line: 9'd5,   gap: 1'b0, req_delay: 0, first: 32'd500, exp_base: 40};
        tbl[5] = '{is_wb: 1'b0, both: 1'b0, line: 9'd5,   gap: 1'b0, req_delay: 1, first: 32'd600, exp_base: 40};
        tbl[6] = '{is_wb: 1'b0, both: 1'b0, line: 9'd511, gap: 1'b1, req_delay: 0, first: 32'd900, exp_base: 4088};

        #1 rst_n = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("idle_busy", 64'(bus.busy), 64'd0);

        for (int v = 0; v < 7; v++) begin
            if (tbl[v].is_wb) begin
                run_wb(tbl[v].line, tbl[v].first, tbl[v].both);
            end else begin
                clear_line(tbl[v].exp_base);
                run_fill(tbl[v].line, tbl[v].first, tbl[v].gap, tbl[v].req_delay, tbl[v].exp_base);
            end
            check("no_addr0_write", 64'(zero_wr), 64'd0);
            check("ab_distinct", 64'(same_ab), 64'd0);
            repeat (2) step();
        end

        // Abort a fill of line 7 after three words have been taken.
        clear_line(56);
        bus.line_idx = 9'd7;
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        i = 0;
        for (int cyc = 0; cyc < 50 && i < 3; cyc++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'd700 + 32'(i);
            take = bus.mem_rvalid && bus.mem_rready;
            step();
            if (take) i++;
        end
        bus.mem_rvalid = 1'b0;
        check("rst_words_taken", 64'(i), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_outputs");
        w0 = wr_count;
        repeat (3) step();
        check("rst_no_we", 64'(wr_count - w0), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_partial_pair", {ram[56], ram[57]}, {32'd700, 32'd701});
        check("rst_partial_rest", ram[58], 32'd0);
        run_fill(9'd7, 32'd700, 1'b0, 0, 56);
        check("no_addr0_write_end", 64'(zero_wr), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
